// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the 1:2 AXI4-Lite crossbar.
// FSM state enums, response codes, decode targets, default windows.
package axi_xbar_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_RESP,
    RD_ERR
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_RESP,
    WR_ERR
  } wr_state_t;

  typedef enum logic [1:0] {
    TGT_MEM,
    TGT_CLINT,
    TGT_NONE
  } tgt_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_SIZE   = 32'h0800_0000;
  localparam logic [31:0] DEF_CLINT_BASE = 32'ha000_0048;
  localparam logic [31:0] DEF_CLINT_SIZE = 32'h0000_0008;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: aw/w/b/ar/r channels, 32b addr/data, 4b strb.
// master modport drives requests; slave modport drives responses.
interface axi_lite_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_addr_dec.sv
// Combinational address decoder: addr -> memory, CLINT or none.
// Ports: addr (32b in), tgt (tgt_t out). CLINT wins on overlap.
module axi_lite_addr_dec
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE,
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE
) (
  input  logic [31:0] addr,
  output tgt_t        tgt
);

  // 33-bit bounds so a window touching 2^32 never wraps
  localparam logic [32:0] MEM_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] MEM_HI = MEM_LO + {1'b0, MEM_SIZE};
  localparam logic [32:0] CL_LO  = {1'b0, CLINT_BASE};
  localparam logic [32:0] CL_HI  = CL_LO + {1'b0, CLINT_SIZE};

  logic [32:0] a;
  logic        clint_hit;
  logic        mem_hit;
  logic        mem_only;

  assign a         = {1'b0, addr};
  assign clint_hit = (a >= CL_LO) && (a < CL_HI);
  assign mem_hit   = (a >= MEM_LO) && (a < MEM_HI);
  assign mem_only  = mem_hit && !clint_hit;

  always_comb begin
    tgt = TGT_NONE;
    unique case (1'b1)
      clint_hit: tgt = TGT_CLINT;
      mem_only:  tgt = TGT_MEM;
      default:   tgt = TGT_NONE;
    endcase
  end

endmodule

// File: rtl/axi_lite_xbar_1to2.sv
// 1-master / 2-slave AXI4-Lite crossbar: s0 = memory, s1 = CLINT.
// Ports: clk, reset (sync, high), m (from LSU), s0/s1 (to slaves).
module axi_lite_xbar_1to2
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE,
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE
) (
  input  logic      clk,
  input  logic      reset,
  axi_lite_if.slave  m,
  axi_lite_if.master s0,
  axi_lite_if.master s1
);

  rd_state_t   rd_q, rd_d;
  logic [31:0] ar_addr_q;
  tgt_t        ar_tgt_q, ar_tgt;

  wr_state_t   wr_q, wr_d;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  tgt_t        aw_tgt_q, aw_tgt;
  logic        aw_done_q, w_done_q;

  // CLINT is read-only: its write response channel is never used
  logic unused_s1;
  assign unused_s1 = ^{s1.awready, s1.wready,
                       s1.bvalid, s1.bresp};

  axi_lite_addr_dec #(
    .MEM_BASE  (MEM_BASE),
    .MEM_SIZE  (MEM_SIZE),
    .CLINT_BASE(CLINT_BASE),
    .CLINT_SIZE(CLINT_SIZE)
  ) u_ar_dec (
    .addr(m.araddr),
    .tgt (ar_tgt)
  );

  axi_lite_addr_dec #(
    .MEM_BASE  (MEM_BASE),
    .MEM_SIZE  (MEM_SIZE),
    .CLINT_BASE(CLINT_BASE),
    .CLINT_SIZE(CLINT_SIZE)
  ) u_aw_dec (
    .addr(m.awaddr),
    .tgt (aw_tgt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= RD_IDLE;
      ar_addr_q <= '0;
      ar_tgt_q  <= TGT_MEM;
    end else begin
      rd_q <= rd_d;
      if (rd_q == RD_IDLE && m.arvalid) begin
        ar_addr_q <= m.araddr;
        ar_tgt_q  <= ar_tgt;
      end
    end
  end

  always_comb begin
    rd_d       = rd_q;
    m.arready  = 1'b0;
    m.rvalid   = 1'b0;
    m.rdata    = '0;
    m.rresp    = RESP_OKAY;
    s0.araddr  = ar_addr_q;
    s0.arvalid = 1'b0;
    s0.rready  = 1'b0;
    s1.araddr  = ar_addr_q;
    s1.arvalid = 1'b0;
    s1.rready  = 1'b0;
    unique case (rd_q)
      RD_IDLE: begin
        m.arready = 1'b1;
        if (m.arvalid)
          rd_d = (ar_tgt == TGT_NONE) ? RD_ERR : RD_REQ;
      end
      RD_REQ: begin
        if (ar_tgt_q == TGT_CLINT) begin
          s1.arvalid = 1'b1;
          if (s1.arready) rd_d = RD_RESP;
        end else begin
          s0.arvalid = 1'b1;
          if (s0.arready) rd_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (ar_tgt_q == TGT_CLINT) begin
          s1.rready = m.rready;
          m.rvalid  = s1.rvalid;
          m.rdata   = s1.rdata;
          m.rresp   = s1.rresp;
        end else begin
          s0.rready = m.rready;
          m.rvalid  = s0.rvalid;
          m.rdata   = s0.rdata;
          m.rresp   = s0.rresp;
        end
        if (m.rvalid && m.rready) rd_d = RD_IDLE;
      end
      RD_ERR: begin
        m.rvalid = 1'b1;
        m.rresp  = RESP_DECERR;
        if (m.rready) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= WR_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_tgt_q  <= TGT_MEM;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wr_q <= wr_d;
      if (wr_q == WR_IDLE && m.awvalid && m.wvalid) begin
        aw_addr_q <= m.awaddr;
        w_data_q  <= m.wdata;
        w_strb_q  <= m.wstrb;
        aw_tgt_q  <= aw_tgt;
      end
      // valid is !done, so done|ready is exactly "handshake seen"
      if (wr_q == WR_REQ) begin
        aw_done_q <= aw_done_q | s0.awready;
        w_done_q  <= w_done_q | s0.wready;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    wr_d       = wr_q;
    m.awready  = 1'b0;
    m.wready   = 1'b0;
    m.bvalid   = 1'b0;
    m.bresp    = RESP_OKAY;
    s0.awaddr  = aw_addr_q;
    s0.awvalid = 1'b0;
    s0.wdata   = w_data_q;
    s0.wstrb   = w_strb_q;
    s0.wvalid  = 1'b0;
    s0.bready  = 1'b0;
    s1.awaddr  = '0;
    s1.awvalid = 1'b0;
    s1.wdata   = '0;
    s1.wstrb   = '0;
    s1.wvalid  = 1'b0;
    s1.bready  = 1'b0;
    unique case (wr_q)
      WR_IDLE: begin
        m.awready = m.awvalid && m.wvalid;
        m.wready  = m.awvalid && m.wvalid;
        if (m.awvalid && m.wvalid)
          wr_d = (aw_tgt == TGT_MEM) ? WR_REQ : WR_ERR;
      end
      WR_REQ: begin
        s0.awvalid = !aw_done_q;
        s0.wvalid  = !w_done_q;
        if ((aw_done_q || s0.awready) &&
            (w_done_q || s0.wready))
          wr_d = WR_RESP;
      end
      WR_RESP: begin
        s0.bready = m.bready;
        m.bvalid  = s0.bvalid;
        m.bresp   = s0.bresp;
        if (s0.bvalid && m.bready) wr_d = WR_IDLE;
      end
      WR_ERR: begin
        m.bvalid = 1'b1;
        m.bresp  = (aw_tgt_q == TGT_CLINT) ?
                   RESP_SLVERR : RESP_DECERR;
        if (m.bready) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

endmodule
